// File: rtl/udp_recv.sv
// GMII receive UDP parser: strips preamble, Ethernet, IPv4 and UDP headers, checks the
// destination fields against the board addresses and emits the payload as 32-bit words.
module udp_recv #(
  parameter logic [47:0] BOARD_MAC_ADDR = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP_ADDR  = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter logic [15:0] BOARD_UDP_PORT = 16'd1234
) (
  input  logic        eth_rxc,
  input  logic        rst,
  input  logic        eth_rxdv,
  input  logic [7:0]  eth_rxd,
  output logic        rec_en,
  output logic [31:0] rec_data,
  output logic        rec_pkt_done,
  output logic [15:0] rec_byte_num,
  output logic [31:0] rec_src_ip,
  output logic        rec_err
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ETH, S_IP, S_UDP, S_DATA, S_DROP} state_t;

  state_t      r_state;
  logic        r_rxdv_d;
  logic [15:0] r_cnt;
  logic [47:0] r_mac;
  logic [7:0]  r_etype_hi;
  logic [3:0]  r_ihl;
  logic        r_proto_ok;
  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [15:0] r_port;
  logic [15:0] r_ulen;
  logic [15:0] r_dlen;
  logic [23:0] r_acc;

  logic [15:0] w_ip_last;
  logic [31:0] w_dst;
  logic        w_last;
  logic [31:0] w_word;

  assign w_ip_last = {10'd0, r_ihl, 2'b00} - 16'd1;
  // With a 20-byte header the last dest-IP byte is the byte being sampled right now.
  assign w_dst     = (r_cnt == 16'd19) ? {r_dst[23:0], eth_rxd} : r_dst;
  assign w_last    = (r_cnt == r_dlen - 16'd1);

  always_comb begin
    w_word = '0;
    case (r_cnt[1:0])
      2'd0:    w_word = {eth_rxd, 24'd0};
      2'd1:    w_word = {r_acc[7:0], eth_rxd, 16'd0};
      2'd2:    w_word = {r_acc[15:0], eth_rxd, 8'd0};
      default: w_word = {r_acc[23:0], eth_rxd};
    endcase
  end

  always_ff @(posedge eth_rxc) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rxdv_d     <= 1'b0;
      r_cnt        <= '0;
      r_mac        <= '0;
      r_etype_hi   <= '0;
      r_ihl        <= '0;
      r_proto_ok   <= 1'b0;
      r_src        <= '0;
      r_dst        <= '0;
      r_port       <= '0;
      r_ulen       <= '0;
      r_dlen       <= '0;
      r_acc        <= '0;
      rec_en       <= 1'b0;
      rec_data     <= '0;
      rec_pkt_done <= 1'b0;
      rec_byte_num <= '0;
      rec_src_ip   <= '0;
      rec_err      <= 1'b0;
    end else begin
      r_rxdv_d     <= eth_rxdv;
      rec_en       <= 1'b0;
      rec_pkt_done <= 1'b0;
      rec_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (eth_rxdv && !r_rxdv_d && eth_rxd == 8'h55) r_state <= S_PRE;
        end
        S_PRE: begin
          if (!eth_rxdv) begin
            r_state <= S_IDLE; r_cnt <= '0;
          end else if (r_cnt < 16'd6 && eth_rxd == 8'h55) begin
            r_cnt <= r_cnt + 16'd1;
          end else if (r_cnt == 16'd6 && eth_rxd == 8'hD5) begin
            r_state <= S_ETH; r_cnt <= '0;
          end else begin
            r_state <= S_DROP; r_cnt <= '0;
          end
        end
        S_ETH: begin
          if (!eth_rxdv) begin
            r_state <= S_IDLE; r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
            if (r_cnt < 16'd6) r_mac <= {r_mac[39:0], eth_rxd};
            if (r_cnt == 16'd12) r_etype_hi <= eth_rxd;
            if (r_cnt == 16'd13) begin
              r_cnt <= '0;
              if ((r_mac == BOARD_MAC_ADDR || r_mac == 48'hffff_ffff_ffff) &&
                  {r_etype_hi, eth_rxd} == 16'h0800) r_state <= S_IP;
              else r_state <= S_DROP;
            end
          end
        end
        S_IP: begin
          if (!eth_rxdv) begin
            r_state <= S_IDLE; r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
            if (r_cnt == 16'd0) begin
              r_ihl <= eth_rxd[3:0];
              if (eth_rxd[7:4] != 4'd4 || eth_rxd[3:0] < 4'd5) begin
                r_state <= S_DROP; r_cnt <= '0;
              end
            end
            if (r_cnt == 16'd9) r_proto_ok <= (eth_rxd == 8'd17);
            if (r_cnt >= 16'd12 && r_cnt <= 16'd15) r_src <= {r_src[23:0], eth_rxd};
            if (r_cnt >= 16'd16 && r_cnt <= 16'd19) r_dst <= {r_dst[23:0], eth_rxd};
            if (r_cnt != 16'd0 && r_cnt == w_ip_last) begin
              r_cnt   <= '0;
              r_state <= (r_proto_ok && w_dst == BOARD_IP_ADDR) ? S_UDP : S_DROP;
            end
          end
        end
        S_UDP: begin
          if (!eth_rxdv) begin
            r_state <= S_IDLE; r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
            if (r_cnt == 16'd2 || r_cnt == 16'd3) r_port <= {r_port[7:0], eth_rxd};
            if (r_cnt == 16'd4 || r_cnt == 16'd5) r_ulen <= {r_ulen[7:0], eth_rxd};
            if (r_cnt == 16'd7) begin
              r_cnt <= '0;
              if (r_port != BOARD_UDP_PORT || r_ulen < 16'd8) begin
                r_state <= S_DROP;
              end else if (r_ulen == 16'd8) begin
                // Empty datagram: report completion without any data word.
                rec_pkt_done <= 1'b1;
                rec_byte_num <= '0;
                rec_src_ip   <= r_src;
                r_state      <= S_DROP;
              end else begin
                r_dlen  <= r_ulen - 16'd8;
                r_state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (!eth_rxdv) begin
            rec_err <= 1'b1;
            r_state <= S_IDLE; r_cnt <= '0;
          end else begin
            r_acc <= {r_acc[15:0], eth_rxd};
            r_cnt <= r_cnt + 16'd1;
            if (r_cnt[1:0] == 2'd3 || w_last) begin
              rec_en   <= 1'b1;
              rec_data <= w_word;
            end
            if (w_last) begin
              rec_pkt_done <= 1'b1;
              rec_byte_num <= r_dlen;
              rec_src_ip   <= r_src;
              r_state      <= S_DROP;
              r_cnt        <= '0;
            end
          end
        end
        S_DROP: begin
          r_cnt <= '0;
          if (!eth_rxdv) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE; r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_recv.sv
// Bench for udp_recv: builds whole frames byte by byte, predicts the payload words and
// completion reports from the frame contents, and compares what the DUT strobes out.
module tb_udp_recv;
  localparam logic [47:0] MAC  = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BC   = 48'hffff_ffff_ffff;
  localparam logic [31:0] IP   = {8'd192, 8'd168, 8'd1, 8'd10};
  localparam logic [15:0] PORT = 16'd1234;

  logic        eth_rxc = 1'b0;
  logic        rst = 1'b1;
  logic        eth_rxdv = 1'b0;
  logic [7:0]  eth_rxd = 8'h00;
  logic        rec_en, rec_pkt_done, rec_err;
  logic [31:0] rec_data, rec_src_ip;
  logic [15:0] rec_byte_num;

  udp_recv dut (
    .eth_rxc(eth_rxc), .rst(rst), .eth_rxdv(eth_rxdv), .eth_rxd(eth_rxd),
    .rec_en(rec_en), .rec_data(rec_data), .rec_pkt_done(rec_pkt_done),
    .rec_byte_num(rec_byte_num), .rec_src_ip(rec_src_ip), .rec_err(rec_err)
  );

  always #4 eth_rxc = ~eth_rxc;

  int total = 0, bad = 0;
  logic [7:0]  fr[$];
  logic [7:0]  pay[$];
  int          pay_start;
  logic [31:0] exp_w[$], got_w[$], exp_s[$], got_s[$];
  logic [15:0] exp_bn[$], got_bn[$];
  int          exp_err = 0, got_err = 0, got_align_bad = 0;
  logic [15:0] last_bn = '0;
  logic [31:0] last_src = '0;

  always @(negedge eth_rxc) begin
    if (rec_en) got_w.push_back(rec_data);
    if (rec_pkt_done) begin
      got_bn.push_back(rec_byte_num);
      got_s.push_back(rec_src_ip);
      if (rec_en !== (rec_byte_num != 16'd0)) got_align_bad++;
    end
    if (rec_err) got_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: words covering payload bytes [0, upto), partial tail zero-filled if 'tail' set.
  task automatic push_words(input int upto, input bit tail);
    logic [31:0] w;
    for (int i = 0; i < upto; i += 4) begin
      if (!tail && i + 4 > upto) break;
      w = '0;
      for (int k = 0; k < 4; k++) w = {w[23:0], (i + k < upto) ? pay[i + k] : 8'h00};
      exp_w.push_back(w);
    end
  endtask

  task automatic frame(input logic [47:0] mac, input logic [15:0] etype, input logic [3:0] ihl,
                       input logic [7:0] proto, input logic [31:0] dip, input logic [31:0] sip,
                       input logic [15:0] port, input int pad, input int cut, input int rst_at,
                       input int gap);
    int  n;
    bit  acc;
    logic [15:0] ulen;
    n = pay.size();
    ulen = 16'(n + 8);
    fr.delete();
    repeat (7) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < 6; i++) fr.push_back(mac[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(8'($urandom));
    fr.push_back(etype[15:8]); fr.push_back(etype[7:0]);
    fr.push_back({4'h4, ihl}); fr.push_back(8'h00);
    for (int i = 0; i < 6; i++) fr.push_back(8'($urandom));
    fr.push_back(8'd64); fr.push_back(proto);
    fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) fr.push_back(sip[31 - 8*i -: 8]);
    for (int i = 0; i < 4; i++) fr.push_back(dip[31 - 8*i -: 8]);
    for (int i = 20; i < 4 * int'(ihl); i++) fr.push_back(8'($urandom));
    fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
    fr.push_back(port[15:8]); fr.push_back(port[7:0]);
    fr.push_back(ulen[15:8]); fr.push_back(ulen[7:0]);
    fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
    pay_start = fr.size();
    for (int i = 0; i < n; i++) fr.push_back(pay[i]);
    for (int i = 0; i < pad; i++) fr.push_back(8'($urandom));

    acc = (mac == MAC || mac == BC) && etype == 16'h0800 && proto == 8'd17 &&
          dip == IP && port == PORT && ihl >= 4'd5;
    if (acc) begin
      if (rst_at >= 0) push_words(rst_at, 1'b0);
      else if (cut >= 0) begin
        push_words(cut, 1'b0);
        exp_err++;
      end else begin
        push_words(n, 1'b1);
        exp_bn.push_back(16'(n)); exp_s.push_back(sip);
        last_bn = 16'(n); last_src = sip;
      end
    end

    for (int i = 0; i < fr.size(); i++) begin
      if (cut >= 0 && i == pay_start + cut) break;
      @(posedge eth_rxc); #1;
      eth_rxdv = 1'b1;
      eth_rxd  = fr[i];
      rst      = (rst_at >= 0 && i == pay_start + rst_at);
      if (rst_at >= 0 && i == pay_start + rst_at + 1) begin
        @(negedge eth_rxc);
        last_bn = '0; last_src = '0;
        chk("rst_data", rec_data, 32'h0);
        chk("rst_byte_num", {16'h0, rec_byte_num}, 32'h0);
        chk("rst_src_ip", rec_src_ip, 32'h0);
        chk("rst_strobes", {29'h0, rec_en, rec_pkt_done, rec_err}, 32'h0);
      end
    end
    @(posedge eth_rxc); #1;
    eth_rxdv = 1'b0; eth_rxd = 8'h00; rst = 1'b0;
    repeat (gap - 1) @(posedge eth_rxc);
  endtask

  task automatic check_batch(input string tag);
    repeat (3) @(posedge eth_rxc);
    @(negedge eth_rxc);
    chk({tag, "_nwords"}, 32'(got_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      chk({tag, "_word"}, got_w[i], exp_w[i]);
    chk({tag, "_ndone"}, 32'(got_bn.size()), 32'(exp_bn.size()));
    for (int i = 0; i < exp_bn.size() && i < got_bn.size(); i++) begin
      chk({tag, "_byte_num"}, {16'h0, got_bn[i]}, {16'h0, exp_bn[i]});
      chk({tag, "_src_ip"}, got_s[i], exp_s[i]);
    end
    chk({tag, "_err"}, 32'(got_err), 32'(exp_err));
    chk({tag, "_done_with_en"}, 32'(got_align_bad), 32'h0);
    chk({tag, "_held_byte_num"}, {16'h0, rec_byte_num}, {16'h0, last_bn});
    chk({tag, "_held_src_ip"}, rec_src_ip, last_src);
    exp_w.delete(); got_w.delete(); exp_bn.delete(); got_bn.delete();
    exp_s.delete(); got_s.delete();
    exp_err = 0; got_err = 0; got_align_bad = 0;
  endtask

  initial begin
    logic [31:0] sip;
    int n, k, cut;
    repeat (3) @(posedge eth_rxc);
    @(negedge eth_rxc);
    chk("reset_en", {31'h0, rec_en}, 32'h0);
    chk("reset_data", rec_data, 32'h0);
    chk("reset_done", {31'h0, rec_pkt_done}, 32'h0);
    chk("reset_byte_num", {16'h0, rec_byte_num}, 32'h0);
    chk("reset_src_ip", rec_src_ip, 32'h0);
    chk("reset_err", {31'h0, rec_err}, 32'h0);
    @(posedge eth_rxc); #1 rst = 1'b0;
    repeat (2) @(posedge eth_rxc);

    pay.delete(); for (int i = 0; i < 8; i++) pay.push_back(8'(i));
    frame(MAC, 16'h0800, 4'd5, 8'd17, IP, 32'hC0A80102, PORT, 0, -1, -1, 4);
    chk("basic_w0", exp_w[0], 32'h00010203);
    check_batch("basic");

    pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    frame(MAC, 16'h0800, 4'd5, 8'd17, IP, 32'h0A000001, PORT, 41, -1, -1, 4);
    check_batch("short_pad");

    pay.delete(); for (int i = 0; i < 8; i++) pay.push_back(8'(i + 32));
    frame(MAC, 16'h0800, 4'd5, 8'd17, IP, 32'h01020304, 16'd1235, 4, -1, -1, 4);
    frame(MAC, 16'h0800, 4'd5, 8'd17, 32'hC0A8010B, 32'h01020304, PORT, 4, -1, -1, 4);
    frame(MAC, 16'h0806, 4'd5, 8'd17, IP, 32'h01020304, PORT, 4, -1, -1, 4);
    check_batch("rejects");
    frame(BC, 16'h0800, 4'd5, 8'd17, IP, 32'h05060708, PORT, 4, -1, -1, 4);
    check_batch("broadcast");

    frame(MAC, 16'h0800, 4'd5, 8'd17, IP, 32'h11111111, PORT, 0, 3, -1, 4);
    check_batch("truncated");

    pay.delete(); for (int i = 0; i < 8; i++) pay.push_back(8'(i + 16));
    frame(MAC, 16'h0800, 4'd5, 8'd17, IP, 32'h22222222, PORT, 4, -1, 3, 4);
    check_batch("reset_mid");
    frame(MAC, 16'h0800, 4'd5, 8'd17, IP, 32'h33333333, PORT, 4, -1, -1, 4);
    check_batch("after_reset");

    pay.delete(); for (int i = 0; i < 6; i++) pay.push_back(8'($urandom));
    frame(MAC, 16'h0800, 4'd6, 8'd17, IP, 32'h44444444, PORT, 0, -1, -1, 1);
    frame(MAC, 16'h0800, 4'd5, 8'd17, IP, 32'h55555555, PORT, 0, -1, -1, 4);
    check_batch("options_b2b");

    for (int f = 0; f < 16; f++) begin
      n = $urandom_range(0, 13);
      pay.delete(); for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      k = $urandom_range(0, 5);
      sip = $urandom;
      cut = (k == 0 && n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      frame((k == 4) ? BC : MAC, (k == 3) ? 16'h0806 : 16'h0800, 4'($urandom_range(5, 7)),
            (k == 5) ? 8'd6 : 8'd17, (k == 2) ? (IP ^ 32'h1) : IP, sip,
            (k == 1) ? (PORT + 16'd1) : PORT, $urandom_range(0, 3), cut, -1,
            $urandom_range(1, 3));
      check_batch("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
